// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-counter display path: widths, the
// converter state encoding and the saturation pattern helper.
package freq_pkg;

  localparam int FREQ_WIDTH = 32;
  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // All-nines pattern in the low 'digits' nibbles, zero above.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] bcd_max(input int digits);
    logic [BCD_W*MAX_DIGITS-1:0] pattern;
    pattern = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      pattern[i*BCD_W +: BCD_W] = (i < digits) ? 4'h9 : 4'h0;
    end
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries cleanly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // per-digit shift-add-3 correction
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/freq_bcd_converter.sv
// Sequential binary-to-packed-BCD converter with valid/ready on both sides;
// results beyond DIGITS decimal digits saturate to all nines and flag overflow.
module freq_bcd_converter
  import freq_pkg::*;
#(
  parameter int WIDTH  = FREQ_WIDTH,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BCD_W*DIGITS-1:0] out_bcd,
  output logic                  out_overflow
);

  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [BCD_W*MAX_DIGITS-1:0] ALL9_WIDE = bcd_max(DIGITS);
  localparam logic [BW-1:0] ALL9 = ALL9_WIDE[BW-1:0];

  bcd_state_t     state_r, state_nxt_s;
  logic [WIDTH-1:0] bin_r;
  logic [BW-1:0]  bcd_r, adj_s, bcd_shift_s;
  logic [CW-1:0]  cnt_r;
  logic           ovf_r, carry_s, ovf_final_s, last_s;
  logic           in_ready_r, out_valid_r, out_ovf_r;
  logic [BW-1:0]  out_bcd_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (bcd_r[g*BCD_W +: BCD_W]),
      .adjusted (adj_s[g*BCD_W +: BCD_W])
    );
  end

  // A 1 leaving the top digit means the running value passed 10^DIGITS-1.
  assign carry_s     = adj_s[BW-1];
  assign bcd_shift_s = {adj_s[BW-2:0], bin_r[WIDTH-1]};
  assign ovf_final_s = ovf_r | carry_s;
  assign last_s      = (cnt_r == CW'(1));

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = SHIFT;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, shift engine and registered handshake/result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      bin_r       <= '0;
      bcd_r       <= '0;
      cnt_r       <= '0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_bcd_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            bin_r <= in_data;
            bcd_r <= '0;
            ovf_r <= 1'b0;
            cnt_r <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          bcd_r <= bcd_shift_s;
          bin_r <= bin_r << 1;
          ovf_r <= ovf_final_s;
          cnt_r <= cnt_r - CW'(1);
          // Result is latched only on the final shift, so nothing partial leaks out.
          if (last_s) begin
            out_bcd_r <= ovf_final_s ? ALL9 : bcd_shift_s;
            out_ovf_r <= ovf_final_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_bcd      = out_bcd_r;
  assign out_overflow = out_ovf_r;

endmodule

// File: doc/freq_bcd_converter.md
# freq_bcd_converter

Downstream stage of the frequency counter. It accepts each gated pulse count as a binary word and converts it to packed BCD for the front-panel display driver, using a sequential shift-add-3 (double-dabble) engine. If the count exceeds the displayable range, the output saturates to all nines and a flag is raised. Both sides use valid/ready handshakes, so the display side can stall without losing the held result.

## Interface
- `WIDTH`, default 32: binary input width; matches the counter's count width.
- `DIGITS`, default 10: number of BCD digits. Must be ≥1. With 32/10 no overflow is possible.
- `clk` in, 1: single clock; all logic on its rising edge.
- `reset` in, 1: asynchronous, active-high. Forces IDLE and the output reset values.
- `in_valid` in, 1: `in_data` is a new count.
- `in_ready` out, 1: engine idle; the input is captured on `in_valid && in_ready`.
- `in_data` in, WIDTH: unsigned binary count.
- `out_valid` out, 1: `out_bcd` and `out_overflow` hold a finished result.
- `out_ready` in, 1: consumer accepts the result on `out_valid && out_ready`.
- `out_bcd` out, 4*DIGITS: packed BCD, digit 0 (units) in bits [3:0].
- `out_overflow` out, 1: `in_data` was greater than 10^DIGITS−1; `out_bcd` is saturated.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`: bin_reg←`in_data`, bcd_reg←0, ovf←0, bit_cnt←WIDTH; go to SHIFT.
- **SHIFT**
  - `in_ready`=0; `in_valid` is ignored, with no queueing.
  - Each cycle, first add 3 to every digit of bcd_reg that is ≥5.
  - Then shift {bcd_reg, bin_reg} left by 1.
  - If the bit shifted out of the top of bcd_reg is 1, set ovf (sticky).
  - Decrement bit_cnt. When bit_cnt reaches 1 on this cycle, go to DONE.
- **DONE**
  - `out_valid`=1.
  - `out_bcd`=bcd_reg, or all digits 4'h9 if ovf. `out_overflow`=ovf.
  - On `out_ready`: go to IDLE.
- `out_bcd` and `out_overflow` are registered. They stay stable from `out_valid` rise until acceptance, and retain their last value after returning to IDLE.
- Width rules:
  - bit_cnt is $clog2(WIDTH+1) bits.
  - Every digit is always ≤9 after each shift, when no overflow occurs.
- Reset mid-operation (any state): the conversion is abandoned. No partial result is ever presented.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_bcd`=0, `out_overflow`=0.
- Latency:
  - Capture at edge E0; the shifts occur on edges E1..E_WIDTH.
  - `out_valid` is high after edge E_WIDTH, i.e. WIDTH cycles after capture (32 by default).
- Throughput:
  - Minimum WIDTH+2 cycles per conversion: capture, WIDTH shifts, then DONE accepted with `out_ready` already high.
  - `in_ready` returns 1 on the cycle after acceptance.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- Backpressure: DONE holds indefinitely while `out_ready`=0. Counts arriving meanwhile are dropped. This is acceptable because the counter refreshes only once per gate period.

## Structure
- Shared package `freq_pkg`:
  - `FREQ_WIDTH`=32, `BCD_W`=4.
  - State enum `bcd_state_t` {IDLE, SHIFT, DONE}.
  - Function `bcd_max(DIGITS)` returning the all-nines pattern.
- Sub-module `bcd_add3`: combinational per-digit correction (4-bit in, 4-bit out, +3 when ≥5). It is instantiated DIGITS times by a generate loop.

## Test plan
- **Reset:** assert `reset` mid-run → `in_ready`=1, `out_valid`=0, `out_bcd`=0, `out_overflow`=0 immediately, without waiting for a clock.
- **Zero and full scale:** `in_data`=0 → `out_bcd`=40'h0000000000, `out_valid` exactly 32 cycles after capture. `in_data`=32'hFFFFFFFF → 40'h4294967295, `out_overflow`=0.
- **Nominal gate count:** `in_data`=100000000 → `out_bcd`=40'h0100000000. A back-to-back second input of 12345 with `out_ready` tied high → 40'h0000012345, with 34 cycles between captures.
- **Overflow:** with DIGITS=8, `in_data`=123456789 → `out_bcd`=32'h99999999, `out_overflow`=1. Then `in_data`=99999999 → 32'h99999999 with `out_overflow`=0.
- **Backpressure:** hold `out_ready`=0 for 20 cycles in DONE → outputs stable, `in_ready`=0, and an `in_valid` pulse during the stall is ignored (the next result is from the following capture).
- **Reset mid-SHIFT:** assert `reset` at shift cycle 10 of a conversion of 987654 → the abandoned conversion never produces `out_valid`. The next conversion of 42 → 40'h0000000042.
